adr_initiator: RTL and testbench

Initiator side of the ADR (Asynchronous DRAM Refresh) handshake with the PCH, clocked at 2 MHz in the core CPLD. It watches the PSU power-fail indication and drives ADR_TRIGGER to the PCH once ADR is armed by the latched ADR modes. It then waits for the filtered ADR_COMPLETE, returns a timed ADR_ACK pulse, and flags a timeout if completion never arrives. The latched modes and filtered ADR_COMPLETE come from the ADR latch block, and oAdrAck_n feeds that block's ADR ACK input.

---
 rtl/adr_initiator.sv | 182 ++++++++++++++++++
 tb/tb_adr_initiator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adr_initiator.sv
// adr_initiator: initiator side of the ADR handshake with the PCH.
// It watches the PSU power-fail, drives ADR_TRIGGER once armed and waits for ADR_COMPLETE.
// On completion it returns a timed ADR_ACK pulse; a missing completion sets a sticky timeout flag.
// The async inputs are double-synchronized, and all outputs are registered alongside the state.
module adr_initiator #(
    parameter int unsigned FILTER_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned ACK_CYCLES     = 2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iAdrMode0,
    input  logic       iAdrMode1,
    input  logic       iPwrFail_n,
    input  logic       iAdrComplete,
    input  logic       iSlpS5_n,
    output logic       oAdrTrigger_n,
    output logic       oAdrAck_n,
    output logic       oAdrTimeout,
    output logic       oAdrBusy,
    output logic [2:0] oAdrState
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_TRIGGER  = 3'd2,
        ST_WAIT     = 3'd3,
        ST_ACK      = 3'd4,
        ST_DONE     = 3'd5,
        ST_TIMEOUT  = 3'd6
    } state_t;

    // Terminal counts of the shared counter (counter starts at 0 on entry).
    localparam logic [15:0] FILT_LAST = 16'(FILTER_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] ACK_LAST  = 16'(ACK_CYCLES - 1);

    // Synchronizer stages, bit order {power-fail_n, complete, slp_s5_n}.
    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic        pf_n_s;
    logic        cmp_s;
    logic        s5_n_s;
    logic        adr_en_s;

    state_t      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic        cmp_prev_q,  cmp_prev_d;
    logic        trig_n_q,    trig_n_d;
    logic        ack_n_q,     ack_n_d;
    logic        timeout_q,   timeout_d;
    logic        busy_q,      busy_d;

    assign pf_n_s   = sync2_q[2];
    assign cmp_s    = sync2_q[1];
    assign s5_n_s   = sync2_q[0];
    assign adr_en_s = iAdrMode0 | iAdrMode1;

    // Two-flop synchronizers for the asynchronous inputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {iPwrFail_n, iAdrComplete, iSlpS5_n};
            sync2_q <= sync1_q;
        end
    end

    // Next-state, shared counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmp_prev_d = cmp_prev_q;
        case (state_q)
            ST_IDLE: begin
                if (adr_en_s && s5_n_s) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!adr_en_s || !s5_n_s) begin
                    state_d = ST_IDLE;
                end else if (!pf_n_s) begin
                    if (cnt_q == FILT_LAST) begin
                        state_d = ST_TRIGGER;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    // Any high sample restarts the power-fail filter.
                    cnt_d = 16'd0;
                end
            end
            ST_TRIGGER: begin
                // Capture the completion level so a stale high is not taken as an edge.
                cmp_prev_d = cmp_s;
                if (!s5_n_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cmp_prev_d = cmp_s;
                if (!s5_n_s) begin
                    state_d = ST_IDLE;
                end else if (cmp_s && !cmp_prev_q) begin
                    // Completion edge wins over a coincident timeout.
                    state_d = ST_ACK;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ACK: begin
                if (!s5_n_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (!s5_n_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The counter restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_d;
        end

        // Outputs are decoded from the next state so they move on the same edge as the state.
        busy_d    = (state_d == ST_TRIGGER) || (state_d == ST_WAIT) || (state_d == ST_ACK);
        trig_n_d  = !busy_d;
        ack_n_d   = (state_d != ST_ACK);
        timeout_d = timeout_q | (state_d == ST_TIMEOUT);
    end

    // FSM state, counter and output registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            cmp_prev_q <= 1'b0;
            trig_n_q   <= 1'b1;
            ack_n_q    <= 1'b1;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmp_prev_q <= cmp_prev_d;
            trig_n_q   <= trig_n_d;
            ack_n_q    <= ack_n_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign oAdrTrigger_n = trig_n_q;
    assign oAdrAck_n     = ack_n_q;
    assign oAdrTimeout   = timeout_q;
    assign oAdrBusy      = busy_q;
    assign oAdrState     = state_q;

endmodule

// File: tb/tb_adr_initiator.sv
// Scoreboard bench for adr_initiator: stimulus pushes every expected output change
// (cycle and value) into a queue; a negedge monitor pops and compares on each change.
module tb_adr_initiator;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       m0    = 1'b1;
    logic       m1    = 1'b0;
    logic       pf_n  = 1'b1;
    logic       cmp   = 1'b0;
    logic       s5_n  = 1'b1;
    logic       trig_n;
    logic       ack_n;
    logic       to_flag;
    logic       busy;
    logic [2:0] st;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic done  = 1'b0;

    typedef struct {
        int         c;
        logic [6:0] v;
    } exp_t;

    exp_t       q[$];
    logic [6:0] pq[$];
    logic [6:0] last = 7'h7F;
    logic [6:0] cur;
    logic [6:0] pv;
    exp_t       e;

    adr_initiator #(
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(100),
        .ACK_CYCLES    (2)
    ) dut (
        .iClk         (clk),
        .iRst         (rst),
        .iAdrMode0    (m0),
        .iAdrMode1    (m1),
        .iPwrFail_n   (pf_n),
        .iAdrComplete (cmp),
        .iSlpS5_n     (s5_n),
        .oAdrTrigger_n(trig_n),
        .oAdrAck_n    (ack_n),
        .oAdrTimeout  (to_flag),
        .oAdrBusy     (busy),
        .oAdrState    (st)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] tup(input logic [2:0] s, input logic tn, input logic an,
                                       input logic t, input logic b);
        return {s, tn, an, t, b};
    endfunction

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int c, input logic [6:0] v);
        exp_t x;
        x.c = c;
        x.v = v;
        q.push_back(x);
    endtask

    // Drop power-fail now; trigger after edge +6, wait state one edge later.
    task automatic start_trigger(input logic t, output int t0);
        t0   = cyc;
        pf_n = 1'b0;
        push(t0 + 6, tup(3'd2, 1'b0, 1'b1, t, 1'b1));
        push(t0 + 7, tup(3'd3, 1'b0, 1'b1, t, 1'b1));
    endtask

    // SLP_S5 low -> IDLE three edges later, then restore inputs -> ARMED three edges later.
    task automatic back_to_armed(input logic t);
        int u;
        u    = cyc;
        s5_n = 1'b0;
        push(u + 3, tup(3'd0, 1'b1, 1'b1, t, 1'b0));
        adv(5);
        s5_n = 1'b1;
        pf_n = 1'b1;
        cmp  = 1'b0;
        u    = cyc;
        push(u + 3, tup(3'd1, 1'b1, 1'b1, t, 1'b0));
        adv(8);
    endtask

    // Monitor: compares each observed output change against the scoreboard head.
    always @(negedge clk) begin
        cur = {st, trig_n, ack_n, to_flag, busy};
        if (q.size() > 0 && q[0].c < cyc) begin
            total++;
            bad++;
            $display("FAIL overdue: change to %b due at cycle %0d, outputs still %b at cycle %0d",
                     q[0].v, q[0].c, cur, cyc);
            e = q.pop_front();
        end
        if (cur !== last) begin
            last = cur;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected: outputs changed to %b at cycle %0d, no change expected",
                         cur, cyc);
            end else begin
                e = q.pop_front();
                total += 2;
                if (e.c != cyc) begin
                    bad++;
                    $display("FAIL timing: change to %b at cycle %0d, required cycle %0d",
                             cur, cyc, e.c);
                end
                if (cur !== e.v) begin
                    bad++;
                    $display("FAIL value: cycle %0d got %b, required %b", cyc, cur, e.v);
                end
            end
        end
        if (pq.size() > 0) begin
            pv = pq.pop_front();
            total++;
            if (cur !== pv) begin
                bad++;
                $display("FAIL steady: cycle %0d got %b, required %b", cyc, cur, pv);
            end
        end
        if (done) begin
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL leftover: %0d expected changes never seen, required 0", q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int u;
        // Reset values seen at first negedge; ARMED once SLP_S5 is synchronized.
        push(1, tup(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        push(4, tup(3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        #12;
        rst = 1'b0;
        adv(8);

        // Nominal: completion 50 cycles after power-fail, ack low for 2 cycles, then DONE.
        start_trigger(1'b0, t);
        adv(50);
        cmp = 1'b1;
        u   = cyc;
        push(u + 3, tup(3'd4, 1'b0, 1'b0, 1'b0, 1'b1));
        push(u + 5, tup(3'd5, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(10);
        back_to_armed(1'b0);

        // Glitch: 3 low, 1 high, 3 low -> filter never reaches 4.
        pf_n = 1'b0;
        adv(3);
        pf_n = 1'b1;
        adv(1);
        pf_n = 1'b0;
        adv(3);
        pf_n = 1'b1;
        adv(8);
        pq.push_back(tup(3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(2);

        // Modes 00: ARMED drops to IDLE, power-fail ignored.
        m0 = 1'b0;
        push(cyc + 1, tup(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(2);
        pf_n = 1'b0;
        adv(15);
        pq.push_back(tup(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(2);
        pf_n = 1'b1;
        m0   = 1'b1;
        push(cyc + 1, tup(3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(8);

        // S5 abort in WAIT_COMPLETE: IDLE, no timeout.
        start_trigger(1'b0, t);
        adv(20);
        back_to_armed(1'b0);

        // Stale completion: high before trigger must fall and rise again.
        cmp = 1'b1;
        start_trigger(1'b0, t);
        adv(20);
        cmp = 1'b0;
        adv(3);
        cmp = 1'b1;
        u   = cyc;
        push(u + 3, tup(3'd4, 1'b0, 1'b0, 1'b0, 1'b1));
        push(u + 5, tup(3'd5, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(10);
        back_to_armed(1'b0);

        // Completion edge on the timeout cycle: ACK wins (trigger at t+6, timeout edge t+107).
        start_trigger(1'b0, t);
        adv(104);
        cmp = 1'b1;
        push(t + 107, tup(3'd4, 1'b0, 1'b0, 1'b0, 1'b1));
        push(t + 109, tup(3'd5, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(10);
        back_to_armed(1'b0);

        // Timeout: flag rises 101 edges after trigger; sticky through S5 return to IDLE.
        start_trigger(1'b0, t);
        push(t + 107, tup(3'd6, 1'b1, 1'b1, 1'b1, 1'b0));
        adv(115);
        back_to_armed(1'b1);

        // Reset mid-ACK: outputs return to reset values without a clock edge.
        start_trigger(1'b1, t);
        adv(10);
        cmp = 1'b1;
        u   = cyc;
        push(u + 3, tup(3'd4, 1'b0, 1'b0, 1'b1, 1'b1));
        adv(4);
        rst  = 1'b1;
        pf_n = 1'b1;
        cmp  = 1'b0;
        push(cyc, tup(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        #5;
        rst = 1'b0;
        push(u + 7, tup(3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        adv(10);
        done = 1'b1;
    end

endmodule
